// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op encodings, FSM states, default latencies and counter sizing.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_RSV6  = 3'd6,
        MD_RSV7  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Counter must hold the larger of the two latencies.
    function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
        int max_cycles;
        max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(max_cycles + 1);
    endfunction

    localparam int MD_CNT_W = md_cnt_width(MD_MULT_CYCLES_DEF, MD_DIV_CYCLES_DEF);

endpackage

// File: rtl/mult_div_unit_md_calc.sv
// Combinational multiply/divide datapath producing the full {hi, lo}
// result for one operation plus a divide-by-zero indication.
module md_calc
    import mult_div_unit_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s_s;
    logic [63:0] prod_u_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] b_safe_s;
    logic [31:0] b_mag_safe_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic [31:0] sq_mag_s;
    logic [31:0] sr_mag_s;
    logic [31:0] sq_s;
    logic [31:0] sr_s;

    // Arithmetic cores; signed division works on magnitudes so the
    // 0x80000000 / -1 overflow case falls out as LO=0x80000000, HI=0.
    always_comb begin
        prod_s_s     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u_s     = {32'd0, a} * {32'd0, b};
        a_mag_s      = a[31] ? (32'd0 - a) : a;
        b_mag_s      = b[31] ? (32'd0 - b) : b;
        b_safe_s     = (b == 32'd0) ? 32'd1 : b;
        b_mag_safe_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
        uq_s         = a / b_safe_s;
        ur_s         = a % b_safe_s;
        sq_mag_s     = a_mag_s / b_mag_safe_s;
        sr_mag_s     = a_mag_s % b_mag_safe_s;
        sq_s         = (a[31] ^ b[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
        sr_s         = a[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
    end

    // Result selection by op.
    always_comb begin
        result      = 64'd0;
        div_by_zero = 1'b0;
        case (op)
            MD_MULT:  result = prod_s_s;
            MD_MULTU: result = prod_u_s;
            MD_DIV: begin
                result      = {sr_s, sq_s};
                div_by_zero = (b == 32'd0);
            end
            MD_DIVU: begin
                result      = {ur_s, uq_s};
                div_by_zero = (b == 32'd0);
            end
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: results are computed at launch,
// held pending, and committed to HI/LO after a modelled latency.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_op_e           op_s;
    logic [63:0]      calc_result_s;
    logic             calc_dbz_s;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q, busy_d;

    assign op_s = md_op_e'(Op);

    md_calc u_md_calc (
        .op          (op_s),
        .a           (A),
        .b           (B),
        .result      (calc_result_s),
        .div_by_zero (calc_dbz_s)
    );

    // Next-state, counter, pending-result and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    case (op_s)
                        MD_MULT, MD_MULTU: begin
                            state_d   = ST_RUN;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            pend_hi_d = calc_result_s[63:32];
                            pend_lo_d = calc_result_s[31:0];
                            pend_wr_d = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_d   = ST_RUN;
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            pend_hi_d = calc_result_s[63:32];
                            pend_lo_d = calc_result_s[31:0];
                            pend_wr_d = ~calc_dbz_s;
                        end
                        MD_MTHI: hi_d = A;
                        MD_MTLO: lo_d = A;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Start is ignored here; the hazard unit is expected to stall.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, placed in the execute stage next to the ALU.
- Consumes the two register-file read operands (RD1 → A, RD2 → B), after forwarding.
- Produces HI/LO values for mfhi/mflo, which flow to writeback and into the register file.
- Asserts Busy so the hazard unit stalls dependent md instructions.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (≥1).
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (≥1).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle strobe; launches the operation given by Op.
- Op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved.
- A  input  32  operand rs (RD1 path).
- B  input  32  operand rt (RD2 path).
- Busy  output  1  operation in flight; registered.
- HI  output  32  HI register; registered.
- LO  output  32  LO register; registered.

Behaviour:
- Clock and reset:
  - One clock, Clk; reset is synchronous and active-high on Reset.
  - Reset clears HI=0, LO=0, Busy=0, counter=0 and pending results.
  - Reset wins over every simultaneous event.
  - Reset mid-operation aborts it; no HI/LO update follows.
- States: IDLE (Busy=0), RUN (Busy=1).
- IDLE transitions, at the edge where Start=1:
  - Op 0–3: pending HI/LO are computed from A/B captured at that edge; counter loads N (MULT_CYCLES or DIV_CYCLES); go to RUN.
  - Op 4: HI<=A at that edge, LO unchanged; stay IDLE; Busy stays 0.
  - Op 5: LO<=A at that edge, HI unchanged; stay IDLE; Busy stays 0.
  - Op 6/7: no effect.
- RUN:
  - Counter decrements each edge.
  - At the edge where counter goes 1→0: HI/LO load the pending values and Busy falls.
  - Busy is therefore high for exactly N cycles after the Start edge.
  - HI/LO hold their old values throughout RUN.
- Start while Busy=1: ignored for all ops, including mthi/mtlo. The hazard unit must stall so this does not occur; the RTL still holds state unchanged.
- Arithmetic:
  - mult: 64-bit signed product; HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: same, unsigned.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
  - Divide by zero (B=0): operation runs full DIV_CYCLES with Busy; HI/LO unchanged at completion.
- Result timing:
  - Results are computed combinationally at launch and held in pending registers.
  - The counter models latency only.
- Back-to-back: a new Start is accepted in the first cycle Busy=0, i.e. the cycle after completion.

Decomposition:
- Shared package/header holds:
  - Op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - Default latencies.
  - Width constant for the counter, clog2 of max(MULT_CYCLES, DIV_CYCLES)+1.
- One sub-module is natural: md_calc, purely combinational.
  - Inputs: Op, A, B.
  - Outputs: 64-bit {hi, lo} result and a div_by_zero flag.
- The top module holds the FSM, counter, pending registers and HI/LO.

Test Plan:
- Reset then idle: Reset=1 for 1 cycle → HI=0, LO=0, Busy=0. Start with Op=6 → no change.
- mult: A=0xFFFFFFFF (-1), B=2, Start → Busy=1 for exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE at the edge Busy falls. Same operands with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div: A=-7 (0xFFFFFFF9), B=2, Start → Busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu with A=7, B=2 → LO=3, HI=1. Overflow case 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi/mtlo: Start Op=4 with A=0x12345678 → HI=0x12345678 next edge, Busy stays 0. Then Op=5 with A=0xCAFEBABE → LO updated, HI kept.
- Start during Busy, and divide by zero:
  - Launch mult; at cycle 2 assert Start Op=4 with A=0xDEAD → ignored; HI/LO end as the mult result.
  - Launch divu with B=0 and prior HI=0x11, LO=0x22 → Busy 10 cycles; HI/LO remain 0x11/0x22.
- Reset mid-operation: launch div, assert Reset at cycle 4 → Busy=0 and HI=LO=0 next edge; no late HI/LO update. A new Start the following cycle is accepted.
